// File: rtl/param_deser_pkg.sv
// -----------------------------------------------------------------------------
// param_deser_pkg
// Shared definitions for the parameterised stream deserializer:
//   deser_state_e : FILL (collecting subwords) / FULL (word presented to consumer)
//   idx_w()       : width of a subword index for a given subword count
// -----------------------------------------------------------------------------
package param_deser_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } deser_state_e;

  // Bits needed to address nsub subwords (never less than 1).
  function automatic int idx_w(input int nsub);
    return (nsub > 1) ? $clog2(nsub) : 1;
  endfunction

endpackage

// File: rtl/param_stream_deserializer_if.sv
// -----------------------------------------------------------------------------
// param_stream_deserializer_if
// Subword input stream and assembled-word output stream of the deserializer.
//   in_val/in_rdy/in_data/in_last : narrow subword stream, LSB-first
//   out_val/out_rdy/out_data/out_nsub : assembled word plus subword count
// Modports:
//   master : the environment (drives subwords, accepts words)
//   slave  : the deserializer
// -----------------------------------------------------------------------------
interface param_stream_deserializer_if #(
  parameter int DATA_W = 32,
  parameter int SUB_W  = 4
);
  import param_deser_pkg::*;

  localparam int NSUB   = DATA_W / SUB_W;
  localparam int NSUB_W = idx_w(NSUB) + 1;

  logic              in_val;
  logic              in_rdy;
  logic [SUB_W-1:0]  in_data;
  logic              in_last;
  logic              out_val;
  logic              out_rdy;
  logic [DATA_W-1:0] out_data;
  logic [NSUB_W-1:0] out_nsub;

  modport master (
    output in_val, in_data, in_last, out_rdy,
    input  in_rdy, out_val, out_data, out_nsub
  );

  modport slave (
    input  in_val, in_data, in_last, out_rdy,
    output in_rdy, out_val, out_data, out_nsub
  );

endinterface

// File: rtl/param_deser_subword_reg.sv
// -----------------------------------------------------------------------------
// param_deser_subword_reg
// One SUB_W-bit slice of the assembled word.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears q
//   clr   : synchronous clear (takes priority over we)
//   we    : write enable
//   d/q   : data in / stored subword
// -----------------------------------------------------------------------------
module param_deser_subword_reg #(
  parameter int SUB_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [SUB_W-1:0] d,
  output logic [SUB_W-1:0] q
);

  // NOTE: the storage itself sits on the async reset, so a reset mid-word
  // discards partial data without any reset term in the data-path mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all clocked state, so every
      // register samples pre-edge values regardless of evaluation order.
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/param_stream_deserializer.sv
// -----------------------------------------------------------------------------
// param_stream_deserializer
// Assembles LSB-first SUB_W-bit subwords into DATA_W-bit words. A word ends
// after NSUB subwords or on in_last, in which case the remaining upper
// subwords are zero- or sign-filled (SIGN_EXT). While a word is presented,
// the first subword of the next one may be accepted in the same cycle the
// word drains.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   flush : synchronous abort of the word in progress (clears out_data)
//   bus   : slave side of param_stream_deserializer_if
// -----------------------------------------------------------------------------
module param_stream_deserializer
  import param_deser_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SUB_W    = 4,
  parameter int SIGN_EXT = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  param_stream_deserializer_if.slave bus
);

  localparam int NSUB   = DATA_W / SUB_W;
  localparam int IDX_W  = idx_w(NSUB);
  localparam int NSUB_W = IDX_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSUB - 1);

  deser_state_e                  state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NSUB_W-1:0]             nsub_q, nsub_d;
  logic [IDX_W-1:0]              wr_idx;
  logic                          in_xfer, out_xfer, word_done;
  logic [SUB_W-1:0]              fill;
  logic [NSUB-1:0][SUB_W-1:0]    sub_q;

  assign bus.out_val  = (state_q == FULL);
  // In FULL a new subword is only taken when the held word drains this cycle.
  assign bus.in_rdy   = reset & ~flush & ((state_q == FILL) | bus.out_rdy);
  assign bus.out_data = sub_q;
  assign bus.out_nsub = nsub_q;

  assign in_xfer   = bus.in_val & bus.in_rdy;
  assign out_xfer  = bus.out_val & bus.out_rdy & ~flush;
  // A subword accepted in FULL always starts the next word at index 0.
  assign wr_idx    = (state_q == FULL) ? '0 : idx_q;
  assign word_done = in_xfer & ((wr_idx == LAST_IDX) | bus.in_last);
  assign fill      = (SIGN_EXT != 0) ? {SUB_W{bus.in_data[SUB_W-1]}} : '0;

  // Each slice takes in_data at the write index, or the extension fill for
  // every slice above it when the word is terminated early.
  for (genvar j = 0; j < NSUB; j++) begin : g_sub
    localparam logic [IDX_W-1:0] J_IDX = IDX_W'(j);
    logic hit, ext;
    assign hit = (J_IDX == wr_idx);
    assign ext = bus.in_last & (J_IDX > wr_idx);

    param_deser_subword_reg #(.SUB_W(SUB_W)) u_reg (
      .clk   (clk),
      .rst_n (reset),
      .clr   (flush),
      .we    (in_xfer & (hit | ext)),
      .d     (hit ? bus.in_data : fill),
      .q     (sub_q[j])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      nsub_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      nsub_q  <= nsub_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    nsub_d  = nsub_q;

    if (flush) begin
      state_d = FILL;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (word_done) begin
            state_d = FULL;
            idx_d   = '0;
          end else if (in_xfer) begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        FULL: begin
          if (word_done) begin
            // Drained and a one-subword word completed in the same cycle.
            state_d = FULL;
            idx_d   = '0;
          end else if (out_xfer) begin
            state_d = FILL;
            idx_d   = in_xfer ? IDX_W'(1) : '0;
          end
        end
        default: begin
          state_d = FILL;
          idx_d   = '0;
        end
      endcase
    end

    if (word_done) begin
      nsub_d = NSUB_W'(wr_idx) + NSUB_W'(1);
    end
  end

endmodule

// File: tb/tb_param_stream_deserializer.sv
// -----------------------------------------------------------------------------
// tb_param_stream_deserializer
// Drives one stimulus stream into two deserializers (SIGN_EXT = 0 and 1).
// A reference model tracks accepted subwords as a plain list and pushes each
// finished word into a scoreboard queue; a monitor compares every presented
// word against the queue head and pops it on an output transfer.
// -----------------------------------------------------------------------------
module tb_param_stream_deserializer;

  localparam int DATA_W = 32;
  localparam int SUB_W  = 4;
  localparam int NSUB   = DATA_W / SUB_W;

  typedef struct {
    logic [DATA_W-1:0] d0;   // zero-filled expectation
    logic [DATA_W-1:0] d1;   // sign-filled expectation
    int                nsub;
  } word_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_val = 1'b0;
  logic             in_last = 1'b0;
  logic             out_rdy = 1'b0;
  logic [SUB_W-1:0] in_data = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  word_t            exp_q[$];
  logic [SUB_W-1:0] part[$];
  bit               m_full = 1'b0;
  int               pop_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_stream_deserializer_if #(.DATA_W(DATA_W), .SUB_W(SUB_W)) bus0 ();
  param_stream_deserializer_if #(.DATA_W(DATA_W), .SUB_W(SUB_W)) bus1 ();

  assign bus0.in_val  = in_val;
  assign bus0.in_data = in_data;
  assign bus0.in_last = in_last;
  assign bus0.out_rdy = out_rdy;
  assign bus1.in_val  = in_val;
  assign bus1.in_data = in_data;
  assign bus1.in_last = in_last;
  assign bus1.out_rdy = out_rdy;

  param_stream_deserializer #(.DATA_W(DATA_W), .SUB_W(SUB_W), .SIGN_EXT(0)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus0)
  );

  param_stream_deserializer #(.DATA_W(DATA_W), .SUB_W(SUB_W), .SIGN_EXT(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus1)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Build the expected word from the collected subwords by plain arithmetic.
  function automatic word_t make_word();
    word_t            w;
    int               n;
    logic [SUB_W-1:0] s0, s1, sfill;
    n      = part.size();
    sfill  = {SUB_W{part[n-1][SUB_W-1]}};
    w.d0   = '0;
    w.d1   = '0;
    w.nsub = n;
    for (int i = 0; i < NSUB; i++) begin
      s0 = (i < n) ? part[i] : '0;
      s1 = (i < n) ? part[i] : sfill;
      w.d0 = w.d0 | (DATA_W'(s0) << (i * SUB_W));
      w.d1 = w.d1 | (DATA_W'(s1) << (i * SUB_W));
    end
    return w;
  endfunction

  // Reference model: evaluated mid-cycle, predicts the coming edge.
  always @(negedge clk) begin : model
    bit exp_rdy, in_x, out_x;
    if (!reset) begin
      check("rst_in_rdy", bus0.in_rdy, 1'b0);
      check("rst_out_val", bus0.out_val, 1'b0);
      part.delete();
      exp_q.delete();
      m_full = 1'b0;
    end else begin
      exp_rdy = !flush && (!m_full || out_rdy);
      check("in_rdy0", bus0.in_rdy, exp_rdy);
      check("in_rdy1", bus1.in_rdy, exp_rdy);
      check("out_val0", bus0.out_val, m_full);
      check("out_val1", bus1.out_val, m_full);
      if (flush) begin
        part.delete();
        exp_q.delete();
        m_full = 1'b0;
      end else begin
        out_x = m_full && out_rdy;
        in_x  = in_val && exp_rdy;
        if (out_x) m_full = 1'b0;
        if (in_x) begin
          part.push_back(in_data);
          if (part.size() == NSUB || in_last) begin
            exp_q.push_back(make_word());
            part.delete();
            m_full = 1'b1;
          end
        end
      end
    end
  end

  // Monitor: compares any presented word against the scoreboard head.
  always @(negedge clk) begin : monitor
    if (reset && !flush && (bus0.out_val || bus1.out_val)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", bus0.out_val | bus1.out_val, 1'b0);
      end else begin
        check("out_data0", bus0.out_data, exp_q[0].d0);
        check("out_data1", bus1.out_data, exp_q[0].d1);
        check("out_nsub0", bus0.out_nsub, exp_q[0].nsub);
        check("out_nsub1", bus1.out_nsub, exp_q[0].nsub);
        if (out_rdy) begin
          void'(exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  // Offer one subword until accepted; called and returns at posedge + 1.
  task automatic put(input logic [SUB_W-1:0] d, input logic last);
    bit acc;
    acc     = 1'b0;
    in_val  = 1'b1;
    in_data = d;
    in_last = last;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = bus0.in_rdy;
      @(posedge clk);
      #1;
    end
    if (!acc) check("put_timeout", acc, 1'b1);
    in_val  = 1'b0;
    in_last = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t0, n0, np;

    // Reset state
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_val", bus0.out_val, 1'b0);
    check("reset_out_data0", bus0.out_data, 32'h0);
    check("reset_out_data1", bus1.out_data, 32'h0);
    check("reset_out_nsub", bus0.out_nsub, 4'd0);
    check("reset_in_rdy", bus0.in_rdy, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Full word 0x1..0x8, out_val one edge after the last transfer
    out_rdy = 1'b1;
    for (int i = 1; i <= NSUB; i++) put(SUB_W'(i), 1'b0);
    check("full_word_val", bus0.out_val, 1'b1);
    check("full_word_data", bus0.out_data, 32'h87654321);
    check("full_word_nsub", bus0.out_nsub, 4'd8);

    // Short word, zero vs sign fill (first subword drains the held word)
    put(4'h5, 1'b0);
    put(4'hA, 1'b1);
    check("short_val", bus0.out_val, 1'b1);
    check("short_zero_fill", bus0.out_data, 32'h000000A5);
    check("short_sign_fill", bus1.out_data, 32'hFFFFFFA5);
    check("short_nsub0", bus0.out_nsub, 4'd2);
    check("short_nsub1", bus1.out_nsub, 4'd2);

    // Back-pressure: word held while out_rdy = 0
    put(4'h9, 1'b0);
    out_rdy = 1'b0;
    for (int i = 1; i <= 7; i++) put(SUB_W'(i), 1'b0);
    in_val  = 1'b1;
    in_data = 4'hC;
    repeat (5) begin
      @(negedge clk);
      check("hold_in_rdy", bus0.in_rdy, 1'b0);
      check("hold_data", bus0.out_data, 32'h76543219);
    end
    @(posedge clk);
    #1;
    out_rdy = 1'b1;
    @(negedge clk);
    check("release_in_rdy", bus0.in_rdy, 1'b1);
    @(posedge clk);
    #1;
    in_val = 1'b0;
    check("release_out_val", bus0.out_val, 1'b0);
    check("release_sub0", bus0.out_data[3:0], 4'hC);
    for (int i = 1; i <= 7; i++) put(SUB_W'(i), 1'b0);
    check("release_word", bus0.out_data, 32'h7654321C);

    // Continuous streaming: 4 words, one every NSUB cycles
    t0 = cyc;
    n0 = pop_cyc.size();
    for (int i = 0; i < 4 * NSUB; i++) put(SUB_W'($urandom), 1'b0);
    check("stream_no_stall", cyc - t0, 4 * NSUB);
    repeat (10) @(posedge clk);
    #1;
    np = pop_cyc.size();
    check("stream_word_count", np - n0, 5);
    for (int k = np - 3; k < np; k++)
      check("stream_spacing", pop_cyc[k] - pop_cyc[k-1], NSUB);

    // Flush mid-word, with a competing subword offered
    for (int i = 0; i < 3; i++) put(SUB_W'($urandom), 1'b0);
    flush   = 1'b1;
    in_val  = 1'b1;
    in_data = 4'hF;
    @(negedge clk);
    check("flush_in_rdy", bus0.in_rdy, 1'b0);
    @(posedge clk);
    #1;
    flush  = 1'b0;
    in_val = 1'b0;
    check("flush_out_val", bus0.out_val, 1'b0);
    check("flush_out_data0", bus0.out_data, 32'h0);
    check("flush_out_data1", bus1.out_data, 32'h0);
    for (int i = NSUB; i >= 1; i--) put(SUB_W'(i), 1'b0);
    check("after_flush_word", bus0.out_data, 32'h12345678);

    // Asynchronous reset mid-word, between clock edges
    for (int i = 0; i < 3; i++) put(SUB_W'($urandom), 1'b0);
    #3 reset = 1'b0;
    #1;
    check("async_rst_out_val", bus0.out_val, 1'b0);
    check("async_rst_data0", bus0.out_data, 32'h0);
    check("async_rst_data1", bus1.out_data, 32'h0);
    check("async_rst_nsub", bus0.out_nsub, 4'd0);
    check("async_rst_in_rdy", bus0.in_rdy, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < NSUB; i++) put(SUB_W'(4'hE - i), 1'b0);
    check("after_reset_word", bus0.out_data, 32'h789ABCDE);

    // Randomized traffic with early termination, back-pressure and flushes
    for (int i = 0; i < 400; i++) begin
      in_val  = 1'($urandom_range(0, 1));
      in_data = SUB_W'($urandom);
      in_last = ($urandom_range(0, 4) == 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      flush   = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #1;
    end
    flush   = 1'b0;
    in_val  = 1'b0;
    in_last = 1'b0;
    out_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_stream_deserializer.md
PARAM_STREAM_DESERIALIZER -- requirements
Module: param_stream_deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, assembled word width.
REQ-002 SHALL have parameter SUB_W, default 4, subword width; DATA_W SHALL be a multiple of SUB_W; NSUB = DATA_W/SUB_W SHALL be >= 2.
REQ-003 SHALL have parameter SIGN_EXT, default 0; 0 = zero-fill on early termination, 1 = sign-fill.
REQ-004 Ports (name  dir  width  meaning):
  clk  in  1  sole clock, rising edge.
  reset  in  1  asynchronous, active-low reset.
  flush  in  1  synchronous abort of a partially assembled word.
  in_val  in  1  subword valid.
  in_rdy  out  1  subword ready.
  in_data  in  SUB_W  subword, LSB-first order.
  in_last  in  1  marks final subword of a short word.
  out_val  out  1  assembled word valid.
  out_rdy  in  1  consumer ready.
  out_data  out  DATA_W  assembled word.
  out_nsub  out  clog2(NSUB)+1  subwords received for out_data (1..NSUB).

Function
REQ-005 Input transfer SHALL occur on a clk edge where in_val and in_rdy are both 1; output transfer where out_val and out_rdy are both 1.
REQ-006 SHALL have states FILL and FULL; out_val = 1 exactly in FULL.
REQ-007 In FILL, in_rdy SHALL be 1; in FULL, in_rdy SHALL equal out_rdy (same-cycle drain and refill).
REQ-008 An internal subword index idx (0..NSUB-1) SHALL select the written subword; an accepted subword SHALL write in_data to bits [idx*SUB_W +: SUB_W] and leave other subwords unchanged.
REQ-009 In FILL, an input transfer with idx = NSUB-1 or in_last = 1 SHALL move to FULL and reset idx to 0; otherwise idx SHALL increment by 1.
REQ-010 On in_last at idx = k < NSUB-1, subwords k+1..NSUB-1 SHALL be written in the same cycle with zeros (SIGN_EXT = 0) or with copies of in_data[SUB_W-1] (SIGN_EXT = 1).
REQ-011 out_nsub SHALL latch idx+1 of the final accepted subword on the transition to FULL.
REQ-012 In FULL, out_data and out_nsub SHALL remain stable until the output transfer.
REQ-013 In FULL, an output transfer without an input transfer SHALL move to FILL with idx = 0.
REQ-014 In FULL, simultaneous output and input transfers SHALL write the new subword at index 0, overwriting it, and then move to FILL with idx = 1; if that subword carries in_last, it SHALL apply REQ-010 with k = 0 and stay in FULL.
REQ-015 Assembly latency SHALL be 1 cycle: out_val SHALL rise on the edge after the final subword transfer; sustained throughput SHALL be one word per NSUB cycles.
REQ-016 flush = 1 SHALL force state FILL, idx 0, out_val 0, and SHALL clear out_data to 0; flush SHALL override any transfer in the same cycle, and in_rdy SHALL be 0 while flush = 1.
REQ-017 in_last SHALL be ignored when no input transfer occurs; in_data SHALL be ignored when in_val = 0.

Reset
REQ-018 reset low SHALL immediately set state FILL, idx 0, out_data 0, out_nsub 0, out_val 0; in_rdy SHALL be 0 while reset is low.
REQ-019 A reset asserted mid-word SHALL discard all partially assembled subwords; the first transfer after deassertion SHALL write index 0.
REQ-020 Subword storage SHALL be reset asynchronously (no data-path reset muxing).

Structure
REQ-021 The state encoding (FILL, FULL) and the index-width helper function SHALL live in shared package param_deser_pkg.
REQ-022 Per-subword storage SHALL be sub-module param_deser_subword_reg (SUB_W-bit register with async active-low reset, sync clear, write enable), instantiated NSUB times in a generate loop.
REQ-023 The top level SHALL contain only the FSM, the idx counter, the extension-fill decode, and output registers.

Verification (DATA_W=32, SUB_W=4)
REQ-024 Send 8 subwords 0x1..0x8 with out_rdy=1 -> out_val rises one cycle after the 8th transfer; out_data=0x87654321, out_nsub=8.
REQ-025 SIGN_EXT=1: send 0x5, then 0xA with in_last -> out_data=0xFFFFFFA5, out_nsub=2; SIGN_EXT=0, same stimulus -> 0x000000A5.
REQ-026 Hold out_rdy=0 in FULL for 5 cycles with in_val=1 -> in_rdy=0 and out_data stable; raise out_rdy with in_data=0xC -> word consumed, next word index 0 = 0xC, idx=1.
REQ-027 Continuous in_val=1 and out_rdy=1 over 4 words -> one word every 8 cycles, no lost or duplicated subwords.
REQ-028 After 3 subwords, assert flush -> out_data=0, then 8 new subwords assemble correctly from index 0; repeat using reset low asynchronously mid-clock instead of flush -> outputs clear without waiting for a clk edge.
